alu_rs_sched: RTL and testbench
===============================

// Module: alu_rs_sched
// PURPOSE
//  Reservation station and issue scheduler in front of the single-cycle ALU execute stage.
//  Buffers decoded ALU/jump ops and snoops the writeback bus for source operands.
//  Issues the oldest entry whose operands are all resolved, one op per cycle, when the ALU is free.
//  A jump flush from the ALU clears all state.
// PARAMETERS
//  DEPTH     4   entries held (2..8); count width is $clog2(DEPTH+1)
//  TAG_W     4   register-tag width; tag value 0 = UNLOCKED (operand valid)
//  OP_W      6   ALU opcode width (sinst_t)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst_n      in   1      synchronous reset, active-low
//  rdy        in   1      global enable; 0 = freeze all state, outputs hold
//  alloc_vld  in   1      decoder offers an op this cycle
//  alloc_op   in   OP_W   opcode
//  alloc_pc   in   32     instruction pc
//  alloc_dx   in   32     operand x value (meaningful when alloc_tx==0)
//  alloc_tx   in   TAG_W  operand x producer tag
//  alloc_dy   in   32     operand y value
//  alloc_ty   in   TAG_W  operand y producer tag
//  alloc_rd   in   5      destination register
//  full       out  1      combinational: count==DEPTH; alloc refused while high
//  count      out  CW     registered number of valid entries
//  wb_en      in   1      writeback broadcast valid
//  wb_tag     in   TAG_W  broadcast tag (never 0 when wb_en)
//  wb_data    in   32     broadcast value
//  alu_free   in   1      ALU can accept an op this cycle
//  iss_vld    out  1      registered: issue fields valid (one-cycle pulse per op)
//  iss_op     out  OP_W   issued opcode
//  iss_pc     out  32     issued pc
//  iss_dx     out  32     resolved operand x
//  iss_dy     out  32     resolved operand y
//  iss_rd     out  5      issued destination
//  flush      in   1      mispredict/jump flush (ALU en_jmp)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): all entries invalid, count=0, iss_vld=0, iss_* = 0.
//  Priority per edge: reset > !rdy (hold) > flush > normal.
//  Flush: all entries invalid, count=0, iss_vld=0; same-cycle alloc and issue are dropped.
//  Storage: compacting queue, slot 0 = oldest; removal shifts younger entries down by one.
//  Alloc: accepted iff alloc_vld && !full (full is taken from the pre-edge count, so an issue on the same edge does not free a slot).
//    The entry is written at the first free slot after compaction.
//  Wakeup: every valid entry with tx==wb_tag (tx!=0) and wb_en takes dx=wb_data and sets tx=0; same for y.
//    Applies to the entry being allocated on that edge (bypass), so a tag broadcast during alloc is not lost.
//  Ready: entry valid && tx==0 && ty==0, evaluated on pre-edge state; a wakeup at edge t makes the entry issuable at edge t+1 at the earliest.
//  Issue: if alu_free and any ready entry, the lowest-index ready entry is removed; its fields are registered onto iss_*, iss_vld=1 for one cycle.
//    Otherwise iss_vld=0 and iss_* hold their last value.
//  count(next) = count + accepted_alloc - issued; alloc, issue and wakeup may all occur on one edge; count never exceeds DEPTH or wraps below 0.
//  Only one wb broadcast per cycle; an entry may be woken on x and y by the same tag.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with alloc_vld=1 -> count=0, iss_vld=0, full=0.
//  T2 ready alloc: op=ADD, tx=ty=0, dx=5, dy=7, alu_free=1 -> iss_vld=1 one cycle after accept, iss_dx=5, iss_dy=7, count back to 0.
//  T3 wakeup+bypass: alloc tx=3 while wb_en=1, wb_tag=3, wb_data=0x1234 on the same edge -> entry holds dx=0x1234, issues on the next edge.
//  T4 ordering: A(tx=2), B(ready), C(ready) allocated in order -> B then C issue; wb tag 2 -> A issues last; iss_pc order B,C,A.
//  T5 full: DEPTH=4 unresolved allocs -> full=1; 5th alloc plus a simultaneous issue -> 5th refused, count=3.
//  T6 flush/freeze: flush=1 with 3 entries and alloc_vld=1 -> count=0, iss_vld=0; rdy=0 during a wb_en -> no state change.

Source files
------------

// File: rtl/alu_rs_sched.sv
// Reservation station and issue scheduler for the ALU execute stage.
// Compacting queue (slot 0 = oldest) with writeback snooping and oldest-ready issue.
module alu_rs_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             alloc_vld,
    input  logic [OP_W-1:0]  alloc_op,
    input  logic [31:0]      alloc_pc,
    input  logic [31:0]      alloc_dx,
    input  logic [TAG_W-1:0] alloc_tx,
    input  logic [31:0]      alloc_dy,
    input  logic [TAG_W-1:0] alloc_ty,
    input  logic [4:0]       alloc_rd,
    output logic             full,
    output logic [CW-1:0]    count,
    input  logic             wb_en,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
    input  logic             alu_free,
    output logic             iss_vld,
    output logic [OP_W-1:0]  iss_op,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_dx,
    output logic [31:0]      iss_dy,
    output logic [4:0]       iss_rd,
    input  logic             flush
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             vld;
        logic [OP_W-1:0]  op;
        logic [31:0]      pc;
        logic [31:0]      dx;
        logic [TAG_W-1:0] tx;
        logic [31:0]      dy;
        logic [TAG_W-1:0] ty;
        logic [4:0]       rd;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          woke  [DEPTH];
    entry_t          new_ent;
    logic [CW-1:0]   count_q, count_d, wr_idx;
    logic            issue, any_ready, alloc_acc;
    logic [IW-1:0]   sel;
    logic            iss_vld_q, iss_vld_d;
    logic [OP_W-1:0] iss_op_q, iss_op_d;
    logic [31:0]     iss_pc_q, iss_pc_d;
    logic [31:0]     iss_dx_q, iss_dx_d;
    logic [31:0]     iss_dy_q, iss_dy_d;
    logic [4:0]      iss_rd_q, iss_rd_d;

    assign full = (count_q == CW'(DEPTH));

    // Writeback snoop applies to stored entries and to the op being allocated this edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (wb_en && ent_q[i].vld && ent_q[i].tx != '0 && ent_q[i].tx == wb_tag) begin
                woke[i].dx = wb_data;
                woke[i].tx = '0;
            end
            if (wb_en && ent_q[i].vld && ent_q[i].ty != '0 && ent_q[i].ty == wb_tag) begin
                woke[i].dy = wb_data;
                woke[i].ty = '0;
            end
        end
        new_ent.vld = 1'b1;
        new_ent.op  = alloc_op;
        new_ent.pc  = alloc_pc;
        new_ent.dx  = alloc_dx;
        new_ent.tx  = alloc_tx;
        new_ent.dy  = alloc_dy;
        new_ent.ty  = alloc_ty;
        new_ent.rd  = alloc_rd;
        if (wb_en && alloc_tx != '0 && alloc_tx == wb_tag) begin
            new_ent.dx = wb_data;
            new_ent.tx = '0;
        end
        if (wb_en && alloc_ty != '0 && alloc_ty == wb_tag) begin
            new_ent.dy = wb_data;
            new_ent.ty = '0;
        end
    end

    // Readiness uses pre-edge tags, so a fresh wakeup issues one edge later at the earliest.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].vld && ent_q[i].tx == '0 && ent_q[i].ty == '0) begin
                any_ready = 1'b1;
                sel       = IW'(i);
            end
        end
        issue = any_ready && alu_free;
    end

    always_comb begin
        alloc_acc = alloc_vld && !full;
        wr_idx    = count_q - CW'(issue);
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = (issue && i >= int'(sel)) ? woke[i + 1] : woke[i];
        end
        ent_d[DEPTH - 1] = issue ? '0 : woke[DEPTH - 1];
        if (alloc_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) ent_d[i] = new_ent;
            end
        end
        count_d   = count_q + CW'(alloc_acc) - CW'(issue);
        iss_vld_d = issue;
        iss_op_d  = iss_op_q;
        iss_pc_d  = iss_pc_q;
        iss_dx_d  = iss_dx_q;
        iss_dy_d  = iss_dy_q;
        iss_rd_d  = iss_rd_q;
        if (issue) begin
            iss_op_d = ent_q[sel].op;
            iss_pc_d = ent_q[sel].pc;
            iss_dx_d = ent_q[sel].dx;
            iss_dy_d = ent_q[sel].dy;
            iss_rd_d = ent_q[sel].rd;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d   = '0;
            iss_vld_d = 1'b0;
            iss_op_d  = iss_op_q;
            iss_pc_d  = iss_pc_q;
            iss_dx_d  = iss_dx_q;
            iss_dy_d  = iss_dy_q;
            iss_rd_d  = iss_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q   <= '0;
            iss_vld_q <= 1'b0;
            iss_op_q  <= '0;
            iss_pc_q  <= '0;
            iss_dx_q  <= '0;
            iss_dy_q  <= '0;
            iss_rd_q  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q   <= count_d;
            iss_vld_q <= iss_vld_d;
            iss_op_q  <= iss_op_d;
            iss_pc_q  <= iss_pc_d;
            iss_dx_q  <= iss_dx_d;
            iss_dy_q  <= iss_dy_d;
            iss_rd_q  <= iss_rd_d;
        end
    end

    assign count   = count_q;
    assign iss_vld = iss_vld_q;
    assign iss_op  = iss_op_q;
    assign iss_pc  = iss_pc_q;
    assign iss_dx  = iss_dx_q;
    assign iss_dy  = iss_dy_q;
    assign iss_rd  = iss_rd_q;
endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched: reset, bypass wakeup, oldest-ready ordering, full, flush and freeze.
module tb_alu_rs_sched;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rdy;
    logic             alloc_vld;
    logic [OP_W-1:0]  alloc_op;
    logic [31:0]      alloc_pc;
    logic [31:0]      alloc_dx;
    logic [TAG_W-1:0] alloc_tx;
    logic [31:0]      alloc_dy;
    logic [TAG_W-1:0] alloc_ty;
    logic [4:0]       alloc_rd;
    logic             full;
    logic [CW-1:0]    count;
    logic             wb_en;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             alu_free;
    logic             iss_vld;
    logic [OP_W-1:0]  iss_op;
    logic [31:0]      iss_pc;
    logic [31:0]      iss_dx;
    logic [31:0]      iss_dy;
    logic [4:0]       iss_rd;
    logic             flush;

    int n_compared   = 0;
    int n_mismatched = 0;

    alu_rs_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .alloc_vld(alloc_vld), .alloc_op(alloc_op), .alloc_pc(alloc_pc),
        .alloc_dx(alloc_dx), .alloc_tx(alloc_tx), .alloc_dy(alloc_dy),
        .alloc_ty(alloc_ty), .alloc_rd(alloc_rd),
        .full(full), .count(count),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
        .alu_free(alu_free),
        .iss_vld(iss_vld), .iss_op(iss_op), .iss_pc(iss_pc),
        .iss_dx(iss_dx), .iss_dy(iss_dy), .iss_rd(iss_rd),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [OP_W-1:0] op, input logic [31:0] pc,
                                 input logic [31:0] dx, input logic [TAG_W-1:0] tx,
                                 input logic [31:0] dy, input logic [TAG_W-1:0] ty,
                                 input logic [4:0] rd);
        alloc_vld = vld;
        alloc_op  = op;
        alloc_pc  = pc;
        alloc_dx  = dx;
        alloc_tx  = tx;
        alloc_dy  = dy;
        alloc_ty  = ty;
        alloc_rd  = rd;
    endtask

    task automatic applyWb(input logic en, input logic [TAG_W-1:0] tag, input logic [31:0] data);
        wb_en   = en;
        wb_tag  = tag;
        wb_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rdy      = 1'b1;
        alu_free = 1'b1;
        flush    = 1'b0;
        applyWb(1'b0, '0, '0);

        // T1 reset with an alloc offered
        applyStimulus(1'b1, 6'h01, 32'h0000_0F00, 32'd1, 4'd0, 32'd2, 4'd0, 5'd1);
        tick();
        tick();
        checkOutput("t1_count", 32'(count), 32'd0);
        checkOutput("t1_iss_vld", 32'(iss_vld), 32'd0);
        checkOutput("t1_full", 32'(full), 32'd0);
        checkOutput("t1_iss_pc", iss_pc, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        tick();

        // T2 ready op issues one cycle after accept
        applyStimulus(1'b1, 6'h01, 32'h0000_0100, 32'd5, 4'd0, 32'd7, 4'd0, 5'd3);
        tick();
        checkOutput("t2_count_acc", 32'(count), 32'd1);
        checkOutput("t2_vld_early", 32'(iss_vld), 32'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        tick();
        checkOutput("t2_iss_vld", 32'(iss_vld), 32'd1);
        checkOutput("t2_iss_dx", iss_dx, 32'd5);
        checkOutput("t2_iss_dy", iss_dy, 32'd7);
        checkOutput("t2_iss_op", 32'(iss_op), 32'h01);
        checkOutput("t2_iss_pc", iss_pc, 32'h0000_0100);
        checkOutput("t2_iss_rd", 32'(iss_rd), 32'd3);
        checkOutput("t2_count", 32'(count), 32'd0);
        tick();
        checkOutput("t2_pulse", 32'(iss_vld), 32'd0);
        checkOutput("t2_hold_dx", iss_dx, 32'd5);

        // T3 bypass wakeup of both operands by the same tag on the alloc edge
        applyStimulus(1'b1, 6'h02, 32'h0000_0200, 32'd0, 4'd3, 32'd0, 4'd3, 5'd4);
        applyWb(1'b1, 4'd3, 32'h0000_1234);
        tick();
        checkOutput("t3_count", 32'(count), 32'd1);
        checkOutput("t3_vld_early", 32'(iss_vld), 32'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        applyWb(1'b0, '0, '0);
        tick();
        checkOutput("t3_iss_vld", 32'(iss_vld), 32'd1);
        checkOutput("t3_iss_dx", iss_dx, 32'h0000_1234);
        checkOutput("t3_iss_dy", iss_dy, 32'h0000_1234);
        checkOutput("t3_iss_pc", iss_pc, 32'h0000_0200);

        // T4 oldest-ready ordering: B, C, then A after its wakeup
        alu_free = 1'b0;
        applyStimulus(1'b1, 6'h03, 32'h0000_0300, 32'd0, 4'd2, 32'h11, 4'd0, 5'd5);
        tick();
        applyStimulus(1'b1, 6'h04, 32'h0000_0304, 32'h21, 4'd0, 32'h22, 4'd0, 5'd6);
        tick();
        applyStimulus(1'b1, 6'h05, 32'h0000_0308, 32'h31, 4'd0, 32'h32, 4'd0, 5'd7);
        tick();
        checkOutput("t4_count3", 32'(count), 32'd3);
        checkOutput("t4_no_issue", 32'(iss_vld), 32'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        alu_free = 1'b1;
        tick();
        checkOutput("t4_first_pc", iss_pc, 32'h0000_0304);
        checkOutput("t4_count2", 32'(count), 32'd2);
        applyWb(1'b1, 4'd2, 32'h0000_AAAA);
        tick();
        checkOutput("t4_second_pc", iss_pc, 32'h0000_0308);
        checkOutput("t4_second_dx", iss_dx, 32'h31);
        checkOutput("t4_count1", 32'(count), 32'd1);
        applyWb(1'b0, '0, '0);
        tick();
        checkOutput("t4_third_vld", 32'(iss_vld), 32'd1);
        checkOutput("t4_third_pc", iss_pc, 32'h0000_0300);
        checkOutput("t4_third_dx", iss_dx, 32'h0000_AAAA);
        checkOutput("t4_third_dy", iss_dy, 32'h11);
        checkOutput("t4_count0", 32'(count), 32'd0);

        // T5 fill with unresolved ops, then refused alloc alongside an issue
        alu_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 6'h06, 32'h0000_0400 + 32'(4 * i), 32'd0, TAG_W'(5 + i),
                          32'h40 + 32'(i), 4'd0, 5'(8 + i));
            tick();
        end
        checkOutput("t5_full", 32'(full), 32'd1);
        checkOutput("t5_count4", 32'(count), 32'd4);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        applyWb(1'b1, 4'd6, 32'h0000_0066);
        tick();
        checkOutput("t5_no_issue", 32'(iss_vld), 32'd0);
        applyWb(1'b0, '0, '0);
        applyStimulus(1'b1, 6'h07, 32'h0000_0410, 32'd1, 4'd0, 32'd1, 4'd0, 5'd12);
        alu_free = 1'b1;
        #1;
        checkOutput("t5_full_pre", 32'(full), 32'd1);
        tick();
        checkOutput("t5_count3", 32'(count), 32'd3);
        checkOutput("t5_iss_pc", iss_pc, 32'h0000_0404);
        checkOutput("t5_iss_dx", iss_dx, 32'h0000_0066);
        checkOutput("t5_full_after", 32'(full), 32'd0);

        // T6 flush drops entries, same-cycle alloc and issue
        flush = 1'b1;
        applyStimulus(1'b1, 6'h08, 32'h0000_0480, 32'd3, 4'd0, 32'd3, 4'd0, 5'd13);
        tick();
        checkOutput("t6_flush_count", 32'(count), 32'd0);
        checkOutput("t6_flush_vld", 32'(iss_vld), 32'd0);
        flush = 1'b0;
        applyStimulus(1'b1, 6'h09, 32'h0000_0500, 32'd0, 4'd9, 32'h50, 4'd0, 5'd14);
        tick();
        checkOutput("t6_alloc_count", 32'(count), 32'd1);
        checkOutput("t6_alloc_vld", 32'(iss_vld), 32'd0);

        // freeze: wakeup and alloc while rdy is low are ignored
        rdy = 1'b0;
        applyStimulus(1'b1, 6'h0A, 32'h0000_0600, 32'd1, 4'd0, 32'd1, 4'd0, 5'd15);
        applyWb(1'b1, 4'd9, 32'h0000_0055);
        tick();
        checkOutput("t6_frz_count", 32'(count), 32'd1);
        checkOutput("t6_frz_vld", 32'(iss_vld), 32'd0);
        rdy = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        applyWb(1'b0, '0, '0);
        tick();
        checkOutput("t6_still_blocked", 32'(iss_vld), 32'd0);
        checkOutput("t6_still_count", 32'(count), 32'd1);
        applyWb(1'b1, 4'd9, 32'h0000_0077);
        tick();
        applyWb(1'b0, '0, '0);
        tick();
        checkOutput("t6_late_vld", 32'(iss_vld), 32'd1);
        checkOutput("t6_late_pc", iss_pc, 32'h0000_0500);
        checkOutput("t6_late_dx", iss_dx, 32'h0000_0077);
        checkOutput("t6_late_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
